lsu_riscv: RTL and testbench
============================

# lsu_riscv

Load/store unit sitting directly downstream of the RISC-V main decoder in the execute stage. Takes the decoder's memory request, access size and direction plus the ALU-computed address and rs2 data. Drives a word-addressed data-memory port with byte enables, and returns the sign/zero-extended load result for write-back. Stalls the core via `lsu_stall_req_o` until the memory acknowledges; flags misaligned or bad-size accesses without touching memory.

## Interface
Parameters:
- none; address and data widths fixed at 32.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk_i`  in  1  core clock; all state updates on the rising edge.
  - `rst_i`  in  1  synchronous, active-high reset.
- Core side:
  - `lsu_req_i`  in  1  memory access requested (decoder `mem_req_o`).
  - `lsu_we_i`  in  1  1 = store, 0 = load (decoder `mem_we_o`).
  - `lsu_size_i`  in  3  funct3 encoding: B=0, H=1, W=2, BU=4, HU=5 (decoder `mem_size_o`).
  - `lsu_addr_i`  in  32  byte address from ALU.
  - `lsu_data_i`  in  32  store data (rs2).
  - `lsu_data_o`  out  32  extended load result, registered.
  - `lsu_stall_req_o`  out  1  hold PC/pipeline while high.
  - `lsu_err_o`  out  1  one-cycle pulse: misaligned or invalid size.
- Memory side:
  - `data_req_o`  out  1  memory request.
  - `data_we_o`  out  1  write enable.
  - `data_be_o`  out  4  byte enables.
  - `data_addr_o`  out  32  word address, low 2 bits forced 0.
  - `data_wdata_o`  out  32  lane-replicated store data.
  - `data_rdata_i`  in  32  read word, valid when `data_ack_i` = 1.
  - `data_ack_i`  in  1  access complete; sampled only while `data_req_o` = 1.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state IDLE.
- IDLE, `lsu_req_i` = 0: stay in IDLE; memory outputs 0.
- IDLE, `lsu_req_i` = 1, access legal:
  - Latch we, size, addr[1:0], word address, byte enables and replicated wdata into registers.
  - Go to BUSY.
- IDLE, `lsu_req_i` = 1, access illegal:
  - Go directly to DONE with error flag set; no memory request is issued.
  - Illegal means any of: size not in {0,1,2,4,5}; H/HU with addr[0] = 1; W with addr[1:0] != 0.
- BUSY:
  - `data_req_o` = 1, with registered we/be/addr/wdata held stable.
  - On `data_ack_i` = 1: if load, register the extended result into `lsu_data_o`; go to DONE.
  - Otherwise stay in BUSY, with no limit on wait cycles.
- DONE:
  - `lsu_stall_req_o` = 0; `lsu_err_o` = 1 if the error flag is set.
  - Unconditionally go to IDLE, even if `lsu_req_i` is still high, so a held request is never replayed.
- Stall: `lsu_stall_req_o` = (`lsu_req_i` & state == IDLE) | (state == BUSY). Combinational from `lsu_req_i`.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: 4'b0011 << addr[1:0].
  - W: 4'b1111.
- Store data: B replicates `lsu_data_i[7:0]` ×4; H replicates `[15:0]` ×2; W passes through.
- Load extraction uses the latched offset:
  - B/BU select byte addr[1:0].
  - H/HU select halfword addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- `lsu_data_o` keeps its value until the next completed load; stores and errors do not change it.

## Timing
- Reset values: all outputs 0, `lsu_data_o` = 0, state IDLE, error flag 0.
- Reset mid-access (BUSY) returns to IDLE at that edge; `data_req_o` falls in the next cycle and any late ack is ignored.
- Request seen in cycle 0 → `data_req_o` high from cycle 1.
- Ack in cycle 1+k → DONE in cycle 2+k; `lsu_data_o` valid from cycle 2+k.
- Stall is high in cycles 0..1+k. Minimum stall is 2 cycles (k = 0).
- Illegal access: stall high in cycle 0 only; `lsu_err_o` pulses in cycle 1.
- `data_ack_i` sampled in IDLE or DONE is ignored.

## Test plan
- LB at addr 0x103, mem word 0x80FF_1234, ack after 3 wait cycles:
  - `data_addr_o` = 0x100, `data_be_o` = 0001 (shifted to 1000), `data_we_o` = 0.
  - `lsu_data_o` = 0xFFFF_FF80; stall high for exactly 5 cycles.
- LHU at 0x202, word 0x8001_0000, ack immediate → `lsu_data_o` = 0x0000_8001, stall 2 cycles. LH at the same address → 0xFFFF_8001.
- SB 0xA5 at 0x301 → `data_wdata_o` = 0xA5A5_A5A5, `data_be_o` = 0010, `data_we_o` = 1. `lsu_data_o` unchanged.
- SW at 0x402 → no `data_req_o`, `lsu_err_o` = 1 for one cycle, stall 1 cycle. Repeat with LW and `lsu_size_i` = 3 → same response.
- `lsu_req_i` held high through DONE → exactly one memory transaction per request.
- Back-to-back LW then SW, with `rst_i` asserted mid-BUSY on a third access → FSM back in IDLE, `data_req_o` = 0, outputs at reset values.

Source files
------------

// File: rtl/lsu_riscv_if.sv
// ============================================================================
// Module      : lsu_riscv_if
// Description : Core-request and data-memory bundle for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_riscv_if;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
    logic        lsu_err_o;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;
    logic        data_ack_i;

    // The LSU is the slave of the core request and the owner of the memory port.
    modport slave (
        input  lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_data_i,
        output lsu_data_o, lsu_stall_req_o, lsu_err_o,
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_rdata_i, data_ack_i
    );

    modport master (
        output lsu_req_i, lsu_we_i, lsu_size_i, lsu_addr_i, lsu_data_i,
        input  lsu_data_o, lsu_stall_req_o, lsu_err_o,
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_rdata_i, data_ack_i
    );
endinterface

`default_nettype wire

// File: rtl/lsu_riscv.sv
// ============================================================================
// Module      : lsu_riscv
// Description : RISC-V load/store unit: byte-enable memory port, load extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_riscv (
    input  wire logic  clk_i,
    input  wire logic  rst_i,
    lsu_riscv_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [2:0]  r_size;
    logic [1:0]  r_off;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_load;

    logic        w_legal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_wdata = bus.lsu_data_i;
        case (bus.lsu_size_i)
            3'd0, 3'd4: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << bus.lsu_addr_i[1:0];
                w_wdata = {4{bus.lsu_data_i[7:0]}};
            end
            3'd1, 3'd5: begin
                w_legal = ~bus.lsu_addr_i[0];
                w_be    = 4'b0011 << bus.lsu_addr_i[1:0];
                w_wdata = {2{bus.lsu_data_i[15:0]}};
            end
            3'd2: begin
                w_legal = (bus.lsu_addr_i[1:0] == 2'b00);
                w_be    = 4'b1111;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Extraction uses the offset latched at request time, not the live address.
    always_comb begin
        w_byte = bus.data_rdata_i[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? bus.data_rdata_i[31:16] : bus.data_rdata_i[15:0];
        case (r_size[1:0])
            2'd0:    w_load = {{24{~r_size[2] & w_byte[7]}}, w_byte};
            2'd1:    w_load = {{16{~r_size[2] & w_half[15]}}, w_half};
            default: w_load = bus.data_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_size  <= 3'd0;
            r_off   <= 2'd0;
            r_addr  <= 32'd0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
            r_load  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.lsu_req_i) begin
                        r_we    <= bus.lsu_we_i;
                        r_size  <= bus.lsu_size_i;
                        r_off   <= bus.lsu_addr_i[1:0];
                        r_addr  <= {bus.lsu_addr_i[31:2], 2'b00};
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_err   <= ~w_legal;
                        r_state <= w_legal ? S_BUSY : S_DONE;
                    end
                end
                S_BUSY: begin
                    if (bus.data_ack_i) begin
                        if (!r_we) begin
                            r_load <= w_load;
                        end
                        r_state <= S_DONE;
                    end
                end
                // A request still held high here is the one just serviced.
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic w_busy;
    assign w_busy = (r_state == S_BUSY);

    assign bus.data_req_o      = w_busy;
    assign bus.data_we_o       = w_busy & r_we;
    assign bus.data_be_o       = w_busy ? r_be    : 4'd0;
    assign bus.data_addr_o     = w_busy ? r_addr  : 32'd0;
    assign bus.data_wdata_o    = w_busy ? r_wdata : 32'd0;
    assign bus.lsu_stall_req_o = (bus.lsu_req_i & (r_state == S_IDLE)) | w_busy;
    assign bus.lsu_err_o       = (r_state == S_DONE) & r_err;
    assign bus.lsu_data_o      = r_load;

endmodule

`default_nettype wire

// File: tb/tb_lsu_riscv.sv
// ============================================================================
// Module      : tb_lsu_riscv
// Description : Self-checking bench for lsu_riscv against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_riscv;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_riscv_if bus ();

    lsu_riscv dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int m_bytes(input logic [2:0] sz);
        if (sz == 3'd0 || sz == 3'd4) return 1;
        if (sz == 3'd1 || sz == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit m_legal(input logic [2:0] sz, input logic [31:0] a);
        case (sz)
            3'd0, 3'd4: return 1'b1;
            3'd1, 3'd5: return (a % 2) == 0;
            3'd2:       return (a % 4) == 0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [31:0] a);
        logic [3:0] be;
        int lo;
        be = 4'd0;
        lo = int'(a % 4);
        for (int i = 0; i < m_bytes(sz); i++) be[lo + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] d);
        logic [31:0] w;
        int n;
        n = m_bytes(sz);
        for (int j = 0; j < 4; j++) w[8*j +: 8] = d[8*(j % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] a,
                                           input logic [31:0] word);
        longint v;
        int n;
        n = m_bytes(sz);
        v = longint'(word) >> (8 * int'(a % 4));
        if (n < 4) begin
            v = v & ((longint'(1) << (8 * n)) - 1);
            if (sz < 3'd4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
        end
        return v[31:0];
    endfunction

    task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] word, input int k,
                          input bit hold, input bit do_rst);
        bit legal;
        int stall_cnt;
        legal     = m_legal(sz, addr);
        stall_cnt = 0;

        @(posedge clk); #1;
        bus.lsu_req_i  = 1'b1;
        bus.lsu_we_i   = we;
        bus.lsu_size_i = sz;
        bus.lsu_addr_i = addr;
        bus.lsu_data_i = data;
        bus.data_ack_i = 1'b0;
        @(negedge clk);
        chk("req_stall", 32'(bus.lsu_stall_req_o), 32'd1);
        chk("req_no_mem", 32'(bus.data_req_o), 32'd0);
        if (bus.lsu_stall_req_o) stall_cnt++;

        if (!legal) begin
            @(posedge clk); #1;
            if (!hold) bus.lsu_req_i = 1'b0;
            bus.data_ack_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("err_pulse", 32'(bus.lsu_err_o), 32'd1);
            chk("err_no_mem", 32'(bus.data_req_o), 32'd0);
            chk("err_data_kept", bus.lsu_data_o, model_data);
            if (bus.lsu_stall_req_o) stall_cnt++;
        end else begin
            for (int c = 0; c <= k; c++) begin
                @(posedge clk); #1;
                if (do_rst && c == 1) begin
                    rst = 1'b1;
                    bus.lsu_req_i = 1'b0;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    bus.data_ack_i   = 1'b1;
                    bus.data_rdata_i = $urandom;
                    model_data = 32'd0;
                    @(negedge clk);
                    chk("rst_req", 32'(bus.data_req_o), 32'd0);
                    chk("rst_we", 32'(bus.data_we_o), 32'd0);
                    chk("rst_be", 32'(bus.data_be_o), 32'd0);
                    chk("rst_addr", bus.data_addr_o, 32'd0);
                    chk("rst_wdata", bus.data_wdata_o, 32'd0);
                    chk("rst_stall", 32'(bus.lsu_stall_req_o), 32'd0);
                    chk("rst_err", 32'(bus.lsu_err_o), 32'd0);
                    chk("rst_data", bus.lsu_data_o, 32'd0);
                    @(posedge clk); #1;
                    bus.data_ack_i = 1'b0;
                    @(negedge clk);
                    chk("late_ack_ignored", 32'(bus.data_req_o), 32'd0);
                    chk("late_ack_data", bus.lsu_data_o, 32'd0);
                    return;
                end
                bus.data_ack_i   = (c == k);
                bus.data_rdata_i = (c == k) ? word : $urandom;
                @(negedge clk);
                chk("busy_req", 32'(bus.data_req_o), 32'd1);
                chk("busy_we", 32'(bus.data_we_o), 32'(we));
                chk("busy_be", 32'(bus.data_be_o), 32'(m_be(sz, addr)));
                chk("busy_addr", bus.data_addr_o, addr & ~32'd3);
                if (we) chk("busy_wdata", bus.data_wdata_o, m_wdata(sz, data));
                chk("busy_stall", 32'(bus.lsu_stall_req_o), 32'd1);
                if (bus.lsu_stall_req_o) stall_cnt++;
            end
            @(posedge clk); #1;
            if (!hold) bus.lsu_req_i = 1'b0;
            bus.data_ack_i   = 1'($urandom_range(0, 1));
            bus.data_rdata_i = $urandom;
            if (!we) model_data = m_load(sz, addr, word);
            @(negedge clk);
            chk("done_req", 32'(bus.data_req_o), 32'd0);
            chk("done_err", 32'(bus.lsu_err_o), 32'd0);
            chk("done_data", bus.lsu_data_o, model_data);
            if (bus.lsu_stall_req_o) stall_cnt++;
        end

        @(posedge clk); #1;
        bus.lsu_req_i  = 1'b0;
        bus.data_ack_i = 1'b0;
        @(negedge clk);
        chk("after_no_replay", 32'(bus.data_req_o), 32'd0);
        chk("after_err", 32'(bus.lsu_err_o), 32'd0);
        chk("after_stall", 32'(bus.lsu_stall_req_o), 32'd0);
        chk("stall_len", 32'(stall_cnt), legal ? 32'(2 + k) : 32'd1);
    endtask

    initial begin
        rst              = 1'b1;
        bus.lsu_req_i    = 1'b0;
        bus.lsu_we_i     = 1'b0;
        bus.lsu_size_i   = 3'd0;
        bus.lsu_addr_i   = 32'd0;
        bus.lsu_data_i   = 32'd0;
        bus.data_rdata_i = 32'd0;
        bus.data_ack_i   = 1'b0;
        model_data       = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_req", 32'(bus.data_req_o), 32'd0);
        chk("reset_be", 32'(bus.data_be_o), 32'd0);
        chk("reset_stall", 32'(bus.lsu_stall_req_o), 32'd0);
        chk("reset_err", 32'(bus.lsu_err_o), 32'd0);
        chk("reset_data", bus.lsu_data_o, 32'd0);

        access(1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF_1234, 3, 1'b0, 1'b0);
        chk("lit_lb", bus.lsu_data_o, 32'hFFFF_FF80);
        access(1'b0, 3'd5, 32'h202, 32'd0, 32'h8001_0000, 0, 1'b0, 1'b0);
        chk("lit_lhu", bus.lsu_data_o, 32'h0000_8001);
        access(1'b0, 3'd1, 32'h202, 32'd0, 32'h8001_0000, 0, 1'b0, 1'b0);
        chk("lit_lh", bus.lsu_data_o, 32'hFFFF_8001);
        access(1'b1, 3'd0, 32'h301, 32'h0000_00A5, 32'd0, 1, 1'b0, 1'b0);
        chk("lit_sb_keeps", bus.lsu_data_o, 32'hFFFF_8001);
        access(1'b1, 3'd2, 32'h402, 32'h1234_5678, 32'd0, 0, 1'b0, 1'b0);
        access(1'b0, 3'd3, 32'h402, 32'd0, 32'd0, 0, 1'b0, 1'b0);
        chk("lit_err_keeps", bus.lsu_data_o, 32'hFFFF_8001);
        access(1'b0, 3'd4, 32'h002, 32'd0, 32'h00C3_0000, 2, 1'b1, 1'b0);
        chk("lit_lbu_hold", bus.lsu_data_o, 32'h0000_00C3);
        access(1'b1, 3'd1, 32'h511, 32'd0, 32'd0, 0, 1'b1, 1'b0);
        access(1'b0, 3'd2, 32'h600, 32'd0, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
        chk("lit_lw", bus.lsu_data_o, 32'hDEAD_BEEF);
        access(1'b1, 3'd2, 32'h604, 32'hCAFE_F00D, 32'd0, 0, 1'b0, 1'b0);
        access(1'b0, 3'd2, 32'h608, 32'd0, 32'h1111_2222, 3, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                   $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
